// File: rtl/uart_loader.sv
// Boot-load sequencer: parses a length / data / checksum word frame from the UART
// word assembler, writes the data words to program memory and releases the CPU on a good image.
module uart_loader #(
    parameter int WORD_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 12,
    parameter int BASE_ADDR      = 0,
    parameter int MAX_WORDS      = 4096,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  word_valid,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  load_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_data,
    output logic                  cpu_rst_n,
    output logic                  done,
    output logic [1:0]            err,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int                    CNT_W    = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [31:0]           TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_LEN,
        LOAD,
        WAIT_SUM,
        DONE,
        ERROR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_LEN  = 2'd1,
        ERR_SUM  = 2'd2,
        ERR_TMO  = 2'd3
    } err_e;

    state_e                  state_q, state_d;
    err_e                    err_q, err_d;
    logic                    valid_q;
    logic [WORD_WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]        remaining_q, remaining_d;
    logic [31:0]             tmo_q, tmo_d;
    logic                    mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_d;
    logic [WORD_WIDTH-1:0]   mem_data_d;
    logic                    cpu_rst_n_d;
    logic                    done_d;
    logic [ADDR_WIDTH:0]     words_loaded_d;
    logic                    accept;

    // word_valid is a level; only its rising edge counts as a new word.
    assign accept = word_valid & ~valid_q;
    assign err    = err_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= WAIT_LEN;
            err_q        <= ERR_NONE;
            valid_q      <= 1'b0;
            sum_q        <= '0;
            remaining_q  <= '0;
            tmo_q        <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= BASE;
            mem_data     <= '0;
            cpu_rst_n    <= 1'b0;
            done         <= 1'b0;
            words_loaded <= '0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            valid_q      <= word_valid;
            sum_q        <= sum_d;
            remaining_q  <= remaining_d;
            tmo_q        <= tmo_d;
            mem_we       <= mem_we_d;
            mem_addr     <= mem_addr_d;
            mem_data     <= mem_data_d;
            cpu_rst_n    <= cpu_rst_n_d;
            done         <= done_d;
            words_loaded <= words_loaded_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        err_d          = err_q;
        sum_d          = sum_q;
        remaining_d    = remaining_q;
        tmo_d          = tmo_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr;
        mem_data_d     = mem_data;
        cpu_rst_n_d    = cpu_rst_n;
        done_d         = done;
        words_loaded_d = words_loaded;

        if (load_req) begin
            // Restart wins over any word accepted on the same edge.
            state_d        = WAIT_LEN;
            err_d          = ERR_NONE;
            sum_d          = '0;
            remaining_d    = '0;
            tmo_d          = '0;
            mem_addr_d     = BASE;
            cpu_rst_n_d    = 1'b0;
            done_d         = 1'b0;
            words_loaded_d = '0;
        end else begin
            unique case (state_q)
                WAIT_LEN: begin
                    tmo_d = '0;
                    if (accept) begin
                        sum_d = '0;
                        if (32'(word_in) > 32'(MAX_WORDS)) begin
                            state_d = ERROR;
                            err_d   = ERR_LEN;
                        end else if (word_in == '0) begin
                            state_d = WAIT_SUM;
                        end else begin
                            state_d     = LOAD;
                            remaining_d = CNT_W'(word_in);
                        end
                    end
                end

                LOAD: begin
                    if (accept) begin
                        mem_we_d       = 1'b1;
                        mem_addr_d     = BASE + words_loaded[ADDR_WIDTH-1:0];
                        mem_data_d     = word_in;
                        words_loaded_d = words_loaded + CNT_W'(1);
                        sum_d          = sum_q + word_in;
                        remaining_d    = remaining_q - CNT_W'(1);
                        tmo_d          = '0;
                        if (remaining_q == CNT_W'(1)) begin
                            state_d = WAIT_SUM;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = ERROR;
                        err_d   = ERR_TMO;
                    end else begin
                        tmo_d = tmo_q + 32'd1;
                    end
                end

                WAIT_SUM: begin
                    if (accept) begin
                        tmo_d = '0;
                        if (word_in == sum_q) begin
                            state_d     = DONE;
                            done_d      = 1'b1;
                            cpu_rst_n_d = 1'b1;
                        end else begin
                            state_d = ERROR;
                            err_d   = ERR_SUM;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = ERROR;
                        err_d   = ERR_TMO;
                    end else begin
                        tmo_d = tmo_q + 32'd1;
                    end
                end

                DONE: begin
                    tmo_d       = '0;
                    done_d      = 1'b1;
                    cpu_rst_n_d = 1'b1;
                end

                ERROR: begin
                    tmo_d       = '0;
                    done_d      = 1'b0;
                    cpu_rst_n_d = 1'b0;
                end

                default: begin
                    state_d = WAIT_LEN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// Randomised scoreboard bench for uart_loader: a frame-level reference model queues
// expected memory writes and final status; a negedge monitor checks every write strobe.
module tb_uart_loader;

    localparam int WW   = 16;
    localparam int AW   = 12;
    localparam int BASE = 0;
    localparam int MAXW = 4096;
    localparam int TMO  = 100;

    typedef logic [WW-1:0] word_q_t[$];
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          word_valid = 1'b0;
    logic [WW-1:0] word_in = '0;
    logic          load_req = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_data;
    logic          cpu_rst_n;
    logic          done;
    logic [1:0]    err;
    logic [AW:0]   words_loaded;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    always #5 clk = ~clk;

    uart_loader #(
        .WORD_WIDTH    (WW),
        .ADDR_WIDTH    (AW),
        .BASE_ADDR     (BASE),
        .MAX_WORDS     (MAXW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .word_valid  (word_valid),
        .word_in     (word_in),
        .load_req    (load_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .cpu_rst_n   (cpu_rst_n),
        .done        (done),
        .err         (err),
        .words_loaded(words_loaded)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: derives writes and final status from the frame rules alone.
    task automatic model_frame(input word_q_t fr, output logic e_done, output logic [1:0] e_err,
                               output int e_wl);
        int            n;
        logic [WW-1:0] sum;
        wr_t           w;
        n      = int'(fr[0]);
        e_done = 1'b0;
        e_err  = 2'd0;
        e_wl   = 0;
        if (n > MAXW) begin
            e_err = 2'd1;
            return;
        end
        sum = '0;
        for (int i = 0; i < n; i++) begin
            w.addr = AW'(BASE + i);
            w.data = fr[1+i];
            exp_q.push_back(w);
            sum = sum + fr[1+i];
        end
        e_wl = n;
        if (fr[n+1] == sum) e_done = 1'b1;
        else                e_err  = 2'd2;
    endtask

    task automatic send_word(input logic [WW-1:0] w, input int hold, input int gap);
        @(posedge clk);
        #1;
        word_valid = 1'b1;
        word_in    = w;
        repeat (hold) @(posedge clk);
        #1;
        word_valid = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_frame(input word_q_t fr);
        for (int i = 0; i < fr.size(); i++)
            send_word(fr[i], $urandom_range(1, 3), $urandom_range(1, 4));
    endtask

    task automatic pulse_load();
        @(posedge clk);
        #1;
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic e_done, input logic [1:0] e_err,
                                input int e_wl);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done"}, 32'(done), 32'(e_done));
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(e_done));
        check({tag, "_err"}, 32'(err), 32'(e_err));
        check({tag, "_words_loaded"}, 32'(words_loaded), 32'(e_wl));
        check({tag, "_writes_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'(BASE));
        check({tag, "_mem_data"}, 32'(mem_data), 32'd0);
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    // Monitor: every write strobe must match the head of the expected-write queue.
    initial begin : monitor
        logic prev_we;
        wr_t  e;
        prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_we = 1'b0;
            end else begin
                if (mem_we) begin
                    check("we_back_to_back", 32'(prev_we), 32'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with none expected at %0t",
                                 mem_addr, mem_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", 32'(mem_addr), 32'(e.addr));
                        check("wr_data", 32'(mem_data), 32'(e.data));
                    end
                end
                prev_we = mem_we;
            end
        end
    end

    initial begin : stimulus
        word_q_t       fr;
        logic          e_done;
        logic [1:0]    e_err;
        int            e_wl;
        int            cyc;
        logic [WW-1:0] sum;
        wr_t           w;

        #7;
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Normal load
        fr = '{16'h0003, 16'h1111, 16'h2222, 16'h3333, 16'h6666};
        model_frame(fr, e_done, e_err, e_wl);
        send_frame(fr);
        check_status("normal", e_done, e_err, e_wl);

        // Bad checksum, then restart clears the error
        pulse_load();
        fr = '{16'h0003, 16'h1111, 16'h2222, 16'h3333, 16'h6667};
        model_frame(fr, e_done, e_err, e_wl);
        send_frame(fr);
        check_status("badsum", e_done, e_err, e_wl);
        pulse_load();
        #1;
        check("restart_err", 32'(err), 32'd0);
        check("restart_words_loaded", 32'(words_loaded), 32'd0);
        check("restart_mem_addr", 32'(mem_addr), 32'(BASE));

        // Empty image
        fr = '{16'h0000, 16'h0000};
        model_frame(fr, e_done, e_err, e_wl);
        send_frame(fr);
        check_status("empty", e_done, e_err, e_wl);

        // Oversized length is rejected on the accept edge
        pulse_load();
        send_word(16'h1001, 1, 0);
        #1;
        check("len_err_immediate", 32'(err), 32'd1);
        check_status("len_err", 1'b0, 2'd1, 0);

        // Timeout, with word_valid held high for 20 cycles on the last data word
        pulse_load();
        send_word(16'h0002, 1, 1);
        @(posedge clk);
        #1;
        word_valid = 1'b1;
        word_in    = 16'hbeef;
        w.addr     = AW'(BASE);
        w.data     = 16'hbeef;
        exp_q.push_back(w);
        @(posedge clk);
        cyc = 0;
        for (int i = 1; i <= 3 * TMO; i++) begin
            @(posedge clk);
            #1;
            if (i == 19) word_valid = 1'b0;
            if (err == 2'd3) begin
                cyc = i;
                break;
            end
        end
        word_valid = 1'b0;
        check("timeout_cycles", 32'(cyc), 32'(TMO));
        check_status("timeout", 1'b0, 2'd3, 1);

        // load_req on the same edge as the second data word of a 4-word frame
        pulse_load();
        send_word(16'h0004, 1, 1);
        w.addr = AW'(BASE);
        w.data = 16'h0a0a;
        exp_q.push_back(w);
        send_word(16'h0a0a, 1, 1);
        @(posedge clk);
        #1;
        word_valid = 1'b1;
        word_in    = 16'h0b0b;
        load_req   = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        check_status("collide", 1'b0, 2'd0, 0);
        check("collide_mem_addr", 32'(mem_addr), 32'(BASE));
        fr = '{16'h0004, 16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h1014};
        model_frame(fr, e_done, e_err, e_wl);
        send_frame(fr);
        check_status("after_collide", e_done, e_err, e_wl);

        // Asynchronous reset while a write strobe is high
        pulse_load();
        send_word(16'h0003, 1, 1);
        w.addr = AW'(BASE);
        w.data = 16'h5555;
        exp_q.push_back(w);
        send_word(16'h5555, 1, 1);
        @(posedge clk);
        #1;
        word_valid = 1'b1;
        word_in    = 16'h7777;
        @(posedge clk);
        #2;
        check("pre_reset_we", 32'(mem_we), 32'd1);
        rst = 1'b0;
        #1;
        check_reset_values("async_reset");
        word_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("reset_pending_writes", 32'(exp_q.size()), 32'd0);
        fr = '{16'h0002, 16'h1234, 16'h4321, 16'h5555};
        model_frame(fr, e_done, e_err, e_wl);
        send_frame(fr);
        check_status("post_reset", e_done, e_err, e_wl);

        // Randomised frames
        for (int f = 0; f < 10; f++) begin
            pulse_load();
            fr.delete();
            if ($urandom_range(0, 7) == 0) begin
                fr.push_back(WW'($urandom_range(MAXW + 1, 65535)));
            end else begin
                fr.push_back(WW'($urandom_range(1, 12)));
                sum = '0;
                for (int i = 0; i < int'(fr[0]); i++) begin
                    fr.push_back(WW'($urandom));
                    sum = sum + fr[$];
                end
                if ($urandom_range(0, 1) == 1) fr.push_back(sum);
                else                           fr.push_back(sum ^ (WW'($urandom) | 16'h0001));
            end
            model_frame(fr, e_done, e_err, e_wl);
            send_frame(fr);
            check_status($sformatf("rand%0d", f), e_done, e_err, e_wl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Boot-load sequencer behind the UART byte-to-word shift register. Consumes its assembled 16-bit words and parses a framed program image: length word, N data words, checksum word.
- Writes the data words into program memory at consecutive addresses, holding the CPU in reset until the image is verified.
- Sits between the UART receive path, the program-memory write port and the CPU reset input.

Parameters:
- WORD_WIDTH, 16, data/length/checksum word width
- ADDR_WIDTH, 12, program-memory address width
- BASE_ADDR, 0, address of first data word
- MAX_WORDS, 4096, largest accepted N; BASE_ADDR+MAX_WORDS must be ≤ 2^ADDR_WIDTH
- TIMEOUT_CYCLES, 5000000, max idle cycles between words mid-frame (32-bit counter)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- word_valid  in  1  assembled-word ready from shift register; level, may stay high several cycles
- word_in  in  WORD_WIDTH  assembled word, stable while word_valid high
- load_req  in  1  single-cycle pulse: abort and restart framing
- mem_we  out  1  program-memory write strobe, one cycle per data word
- mem_addr  out  ADDR_WIDTH  write address
- mem_data  out  WORD_WIDTH  write data
- cpu_rst_n  out  1  CPU reset, low = CPU held
- done  out  1  image loaded and checksum matched
- err  out  2  0 none, 1 length, 2 checksum, 3 timeout
- words_loaded  out  ADDR_WIDTH+1  data words written in current frame

Behaviour:
- All outputs registered.
- Reset values: mem_we=0, mem_addr=BASE_ADDR, mem_data=0, cpu_rst_n=0, done=0, err=0, words_loaded=0. Reset also clears the edge-detect flop, running sum, remaining count and timeout counter. State WAIT_LEN.
- Reset asserted at any time, including mid-frame, returns immediately to the reset values. No partial write strobe is left high.
- Word accept: one accept on the clock edge that samples word_valid=1 with previous-sample=0 (rising edge). word_valid held high yields exactly one accept.
- States:
  - WAIT_LEN: on accept, N=word_in.
    - N>MAX_WORDS → ERROR, err=1.
    - N==0 → WAIT_SUM.
    - Otherwise remaining=N, sum=0 → LOAD.
    - No timeout in this state.
  - LOAD: each accept drives mem_we=1, mem_addr=BASE_ADDR+words_loaded and mem_data=word_in for the one cycle after the accept edge (latency 1). Then words_loaded+=1, sum=(sum+word_in) mod 2^16, remaining-=1. When remaining reaches 0 → WAIT_SUM.
  - WAIT_SUM: on accept, word_in==sum → DONE. Otherwise → ERROR, err=2.
  - DONE: done=1, cpu_rst_n=1. Further accepts ignored.
  - ERROR: cpu_rst_n=0, done=0, err holds its code. Further accepts ignored.
- The length word and checksum word are never written to memory and never added to sum.
- Timeout: counter runs in LOAD and WAIT_SUM and clears on every accept. Reaching TIMEOUT_CYCLES → ERROR, err=3.
- load_req from any state, on the next edge:
  - state WAIT_LEN; cpu_rst_n=0, done=0, err=0, words_loaded=0
  - sum, remaining and timeout counter cleared; mem_addr=BASE_ADDR
  - memory contents untouched
- load_req and an accept on the same edge: load_req wins, the word is discarded, no mem_we.
- The edge-detect flop keeps sampling through load_req, so a word_valid already high across a restart is not re-accepted.
- mem_we is never high for two consecutive cycles: accepts are at least 2 cycles apart by construction.
- Address arithmetic is ADDR_WIDTH bits. It cannot wrap given the MAX_WORDS constraint.

Test Plan:
- Normal load, frame 0x0003, 0x1111, 0x2222, 0x3333, 0x6666 → mem_we pulses at addr 0,1,2 with those data; words_loaded=3; done=1, cpu_rst_n=1, err=0.
- Same frame with checksum 0x6667 → three writes occur, then err=2, done=0, cpu_rst_n=0. A following load_req clears err and returns to WAIT_LEN.
- Empty image, frame 0x0000, 0x0000 → no mem_we, done=1. Length 0x1001 with MAX_WORDS=4096 → err=1 immediately, no writes.
- Timeout with TIMEOUT_CYCLES=100: length 0x0002 plus one data word, then silence → err=3 100 cycles after the last accept; word_valid held high for 20 cycles before that produces only one write.
- load_req pulsed on the same edge as the second data word of a 4-word frame → no write for that word; state WAIT_LEN. A fresh full frame then writes from BASE_ADDR and reaches done.
- rst pulled low between data words → all outputs at reset values asynchronously, before the next clock edge. After release, a complete frame loads correctly.
